serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor. Computes diff = a - b, LSB first, one bit per clock.
- Each bit step uses a registered borrow and a one-bit full-subtractor cell. This is the inverse-direction companion to the team's one-bit adder.
- Valid/ready handshake on both sides. Sits between an operand producer and a result consumer in area-constrained datapaths.

---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/serial_subtractor_if.sv | 25 ++
 rtl/serial_subtractor_cell.sv | 11 +
 rtl/serial_subtractor.sv | 87 ++++++++
 tb/tb_serial_subtractor.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sub_state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
interface serial_subtractor_if
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow_out
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow_out
    );
endinterface

// File: rtl/serial_subtractor_cell.sv
// One-bit full subtractor: a - b - bin, producing the difference bit and borrow.
module one_bit_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);
    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b, LSB first, one bit per clock.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic          clk,
    input logic          resetn,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sub_state_t       state;
    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] shift_b;
    logic [WIDTH-1:0] diff_sr;
    logic [WIDTH-1:0] diff_next;
    logic [CW-1:0]    count;
    logic             borrow;
    logic             borrow_res;
    logic             d_bit;
    logic             b_next;

    one_bit_subtractor u_cell (
        .a    (shift_a[0]),
        .b    (shift_b[0]),
        .bin  (borrow),
        .diff (d_bit),
        .bout (b_next)
    );

    // New bits enter at the MSB so bit i lands at diff[i] after WIDTH steps.
    generate
        if (WIDTH == 1) begin : g_w1
            assign diff_next = d_bit;
        end else begin : g_wn
            assign diff_next = {d_bit, diff_sr[WIDTH-1:1]};
        end
    endgenerate

    assign bus.in_ready   = (state == IDLE);
    assign bus.out_valid  = (state == DONE);
    assign bus.diff       = diff_sr;
    assign bus.borrow_out = borrow_res;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            shift_a    <= '0;
            shift_b    <= '0;
            diff_sr    <= '0;
            count      <= '0;
            borrow     <= 1'b0;
            borrow_res <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        shift_a <= bus.a;
                        shift_b <= bus.b;
                        borrow  <= 1'b0;
                        count   <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    shift_a <= shift_a >> 1;
                    shift_b <= shift_b >> 1;
                    diff_sr <= diff_next;
                    borrow  <= b_next;
                    count   <= count + 1'b1;
                    if (count == LAST) begin
                        borrow_res <= b_next;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor at WIDTH 8, 13 and 1.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8))  bus8 ();
    serial_subtractor_if #(.WIDTH(13)) bus13 ();
    serial_subtractor_if #(.WIDTH(1))  bus1 ();

    serial_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .resetn(resetn), .bus(bus8));
    serial_subtractor #(.WIDTH(13)) dut13 (.clk(clk), .resetn(resetn), .bus(bus13));
    serial_subtractor #(.WIDTH(1))  dut1  (.clk(clk), .resetn(resetn), .bus(bus1));

    // Reference: {borrow, diff} = {a < b, (a - b) mod 2^w}
    function automatic logic [63:0] ref_sub(input int w, input logic [63:0] av, input logic [63:0] bv);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return ((av < bv) ? (64'd1 << w) : 64'd0) | ((av - bv) & mask);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv);
        int lat;
        logic [63:0] exp;
        exp = ref_sub(8, 64'(av), 64'(bv));
        check({tag, "_accept_ready"}, 64'(bus8.in_ready), 64'd1);
        bus8.a = av;
        bus8.b = bv;
        bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        lat = 0;
        while (!bus8.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd8);
        check({tag, "_result"}, 64'({bus8.borrow_out, bus8.diff}), exp);
    endtask

    task automatic op1(input string tag, input logic av, input logic bv);
        int lat;
        logic [63:0] exp;
        exp = ref_sub(1, 64'(av), 64'(bv));
        bus1.a = av;
        bus1.b = bv;
        bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        lat = 0;
        while (!bus1.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd1);
        check({tag, "_result"}, 64'({bus1.borrow_out, bus1.diff}), exp);
    endtask

    initial begin
        int acc8, res8, acc13, res13;
        logic [63:0] q8[$];
        logic [63:0] q13[$];

        resetn = 1'b1;
        bus8.in_valid = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.out_ready = 1'b1;
        bus13.in_valid = 1'b0; bus13.a = '0; bus13.b = '0; bus13.out_ready = 1'b1;
        bus1.in_valid = 1'b0;  bus1.a = '0;  bus1.b = '0;  bus1.out_ready = 1'b1;
        #1 resetn = 1'b0;
        #1;
        check("rst_in_ready", 64'(bus8.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus8.out_valid), 64'd0);
        check("rst_diff", 64'(bus8.diff), 64'd0);
        check("rst_borrow", 64'(bus8.borrow_out), 64'd0);
        check("rst_in_ready13", 64'(bus13.in_ready), 64'd1);
        check("rst_in_ready1", 64'(bus1.in_ready), 64'd1);
        tick();
        resetn = 1'b1;
        tick();

        // Basic vectors with an always-ready consumer
        op8("v05_03", 8'h05, 8'h03);
        tick();
        check("v05_03_ready_after", 64'(bus8.in_ready), 64'd1);
        check("v05_03_valid_after", 64'(bus8.out_valid), 64'd0);
        op8("v03_05", 8'h03, 8'h05);
        tick();
        op8("v00_01", 8'h00, 8'h01);
        tick();
        op8("vff_ff", 8'hFF, 8'hFF);
        tick();

        // Backpressure in DONE with a busy producer
        bus8.out_ready = 1'b0;
        op8("bp", 8'h3C, 8'h5A);
        for (int i = 0; i < 5; i++) begin
            bus8.in_valid = 1'b1;
            bus8.a = 8'($urandom);
            bus8.b = 8'($urandom);
            tick();
            check("bp_diff", 64'(bus8.diff), 64'hE2);
            check("bp_borrow", 64'(bus8.borrow_out), 64'd1);
            check("bp_in_ready", 64'(bus8.in_ready), 64'd0);
            check("bp_out_valid", 64'(bus8.out_valid), 64'd1);
        end
        bus8.in_valid = 1'b0;
        bus8.out_ready = 1'b1;
        tick();
        check("bp_consumed", 64'(bus8.out_valid), 64'd0);
        check("bp_idle", 64'(bus8.in_ready), 64'd1);

        // Asynchronous reset three cycles into RUN
        bus8.a = 8'h80;
        bus8.b = 8'h01;
        bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        tick();
        tick();
        tick();
        resetn = 1'b0;
        #1;
        check("mid_rst_in_ready", 64'(bus8.in_ready), 64'd1);
        check("mid_rst_out_valid", 64'(bus8.out_valid), 64'd0);
        check("mid_rst_diff", 64'(bus8.diff), 64'd0);
        check("mid_rst_borrow", 64'(bus8.borrow_out), 64'd0);
        tick();
        resetn = 1'b1;
        tick();
        op8("post_rst", 8'h80, 8'h01);
        tick();

        // WIDTH=1 truth table
        op1("w1_00", 1'b0, 1'b0);
        tick();
        op1("w1_10", 1'b1, 1'b0);
        tick();
        op1("w1_01", 1'b0, 1'b1);
        tick();
        op1("w1_11", 1'b1, 1'b1);
        tick();

        // Randomized traffic on WIDTH 8 and 13 concurrently
        acc8 = 0; res8 = 0; acc13 = 0; res13 = 0;
        for (int cyc = 0; cyc < 80000 && (res8 < 1000 || res13 < 1000); cyc++) begin
            bus8.in_valid = (acc8 < 1000) && ($urandom_range(3) != 0);
            bus8.a = 8'($urandom);
            bus8.b = 8'($urandom);
            bus8.out_ready = ($urandom_range(3) != 0);
            bus13.in_valid = (acc13 < 1000) && ($urandom_range(3) != 0);
            bus13.a = 13'($urandom);
            bus13.b = 13'($urandom);
            bus13.out_ready = ($urandom_range(3) != 0);
            #1;
            if (bus8.in_valid && bus8.in_ready) begin
                q8.push_back(ref_sub(8, 64'(bus8.a), 64'(bus8.b)));
                acc8++;
            end
            if (bus8.out_valid && bus8.out_ready) begin
                check("rand8_expected_pending", 64'(q8.size() > 0), 64'd1);
                if (q8.size() > 0)
                    check("rand8_result", 64'({bus8.borrow_out, bus8.diff}), q8.pop_front());
                res8++;
            end
            if (bus13.in_valid && bus13.in_ready) begin
                q13.push_back(ref_sub(13, 64'(bus13.a), 64'(bus13.b)));
                acc13++;
            end
            if (bus13.out_valid && bus13.out_ready) begin
                check("rand13_expected_pending", 64'(q13.size() > 0), 64'd1);
                if (q13.size() > 0)
                    check("rand13_result", 64'({bus13.borrow_out, bus13.diff}), q13.pop_front());
                res13++;
            end
            tick();
        end
        check("rand8_results", 64'(res8), 64'd1000);
        check("rand8_leftover", 64'(q8.size()), 64'd0);
        check("rand13_results", 64'(res13), 64'd1000);
        check("rand13_leftover", 64'(q13.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
